lcd_pixel_unpacker: RTL and testbench

- Read-side counterpart of the camera write arbitration path. Pulls paired 16-bit words from the two SDRAM read FIFOs (Rd1/Rd2) on LCD pixel requests.
- Unpacks each pair into 8-bit R/G/B plus the embedded 8-bit gray sample, and presents registered pixels to the LTM LCD timing controller.
- Tracks frame position, fills black on FIFO underflow and flags frame-sync errors.

---
 rtl/lcd_pixel_unpacker.sv | 230 +++++++++++++++++++++++
 tb/tb_lcd_pixel_unpacker.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_unpacker.sv
// LCD read-side pixel unpacker.
// Pops paired 16-bit words from the Rd1/Rd2 SDRAM read FIFOs on LCD pixel
// requests, unpacks them into R/G/B plus the embedded gray sample, and
// presents registered pixels with their raster position. A FIFO underflow
// produces a fill pixel, and an early frame start is flagged as an error.
module lcd_pixel_unpacker #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iFrameStart,
  input  logic        iLcd_Req,
  input  logic        iShowGray,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  input  logic        iRd1_empty,
  input  logic        iRd2_empty,
  output logic        oRd_req,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic [7:0]  oGray,
  output logic        oPix_valid,
  output logic [15:0] oX,
  output logic [15:0] oY,
  output logic        oUnderflow,
  output logic [15:0] oUnderflow_cnt,
  output logic        oFrame_err
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    ACTIVE     = 2'd1,
    DRAIN      = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        uf_q, uf_d;
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic        err_q, err_d;

  // Stage 1: request accepted, FIFO data arrives next cycle
  logic        s1_vld_q, s1_vld_d;
  logic        s1_uf_q, s1_uf_d;
  logic [15:0] s1_x_q, s1_x_d;
  logic [15:0] s1_y_q, s1_y_d;

  // Stage 2: registered pixel outputs
  logic        pix_vld_q, pix_vld_d;
  logic [7:0]  r_q, r_d;
  logic [7:0]  g_q, g_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  gray_q, gray_d;
  logic [15:0] px_q, px_d;
  logic [15:0] py_q, py_d;

  logic        rd_req;
  logic        fifo_ok;
  logic [15:0] cur_x, cur_y;
  logic [7:0]  unp_gray;

  // Control, position and underflow state registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q  <= WAIT_FRAME;
      x_q      <= '0;
      y_q      <= '0;
      uf_q     <= 1'b0;
      uf_cnt_q <= '0;
      err_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_uf_q  <= 1'b0;
      s1_x_q   <= '0;
      s1_y_q   <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      uf_q     <= uf_d;
      uf_cnt_q <= uf_cnt_d;
      err_q    <= err_d;
      s1_vld_q <= s1_vld_d;
      s1_uf_q  <= s1_uf_d;
      s1_x_q   <= s1_x_d;
      s1_y_q   <= s1_y_d;
    end
  end

  // Frame FSM, FIFO read strobe, raster position and underflow accounting
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    uf_d     = uf_q;
    uf_cnt_d = uf_cnt_q;
    err_d    = 1'b0;
    s1_vld_d = 1'b0;
    s1_uf_d  = 1'b0;
    s1_x_d   = s1_x_q;
    s1_y_d   = s1_y_q;
    rd_req   = 1'b0;
    fifo_ok  = ~iRd1_empty & ~iRd2_empty;
    cur_x    = x_q;
    cur_y    = y_q;

    case (state_q)
      WAIT_FRAME, DRAIN: begin
        state_d = (state_q == DRAIN) ? WAIT_FRAME : state_q;
        if (iFrameStart) begin
          state_d  = ACTIVE;
          x_d      = '0;
          y_d      = '0;
          uf_d     = 1'b0;
          uf_cnt_d = '0;
        end
      end
      ACTIVE: begin
        // An early frame start restarts the raster; a request in the same
        // cycle is served as the first pixel of the new frame.
        if (iFrameStart) begin
          err_d    = 1'b1;
          cur_x    = '0;
          cur_y    = '0;
          x_d      = '0;
          y_d      = '0;
          uf_d     = 1'b0;
          uf_cnt_d = '0;
        end
        if (iLcd_Req) begin
          rd_req   = fifo_ok;
          s1_vld_d = 1'b1;
          s1_uf_d  = ~fifo_ok;
          s1_x_d   = cur_x;
          s1_y_d   = cur_y;
          if (!fifo_ok) begin
            uf_d = 1'b1;
            if (uf_cnt_d != 16'hFFFF) begin
              uf_cnt_d = uf_cnt_d + 16'd1;
            end
          end
          if (cur_x == X_LAST) begin
            x_d = '0;
            if (cur_y == Y_LAST) begin
              state_d = DRAIN;
            end else begin
              y_d = cur_y + 16'd1;
            end
          end else begin
            x_d = cur_x + 16'd1;
          end
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  assign unp_gray = {iRd1_data[15], iRd1_data[1:0], iRd2_data[15],
                     iRd2_data[11:10], iRd2_data[1:0]};

  // Unpack the FIFO word pair (or fill on underflow) into the output pixel
  always_comb begin
    pix_vld_d = s1_vld_q;
    r_d       = r_q;
    g_d       = g_q;
    b_d       = b_q;
    gray_d    = gray_q;
    px_d      = px_q;
    py_d      = py_q;
    if (s1_vld_q) begin
      px_d = s1_x_q;
      py_d = s1_y_q;
      if (s1_uf_q) begin
        {r_d, g_d, b_d} = FILL_RGB;
        gray_d          = '0;
      end else begin
        gray_d = unp_gray;
        if (iShowGray) begin
          r_d = unp_gray;
          g_d = unp_gray;
          b_d = unp_gray;
        end else begin
          r_d = iRd2_data[9:2];
          g_d = {iRd1_data[14:10], iRd2_data[14:12]};
          b_d = iRd1_data[9:2];
        end
      end
    end
  end

  // Output pixel registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      pix_vld_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      gray_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
    end else begin
      pix_vld_q <= pix_vld_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      gray_q    <= gray_d;
      px_q      <= px_d;
      py_q      <= py_d;
    end
  end

  assign oRd_req        = rd_req;
  assign oR             = r_q;
  assign oG             = g_q;
  assign oB             = b_q;
  assign oGray          = gray_q;
  assign oPix_valid     = pix_vld_q;
  assign oX             = px_q;
  assign oY             = py_q;
  assign oUnderflow     = uf_q;
  assign oUnderflow_cnt = uf_cnt_q;
  assign oFrame_err     = err_q;

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Directed bench for lcd_pixel_unpacker: a full-size instance (800x480) and a
// small-raster instance (4x2) share all inputs and the clock.
module tb_lcd_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fs = 1'b0;
  logic        req = 1'b0;
  logic        show = 1'b0;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  logic        e1 = 1'b0;
  logic        e2 = 1'b0;

  logic        rdreq, vld, uf, err;
  logic [7:0]  r, g, b, gray;
  logic [15:0] x, y, ufcnt;

  logic        rdreq_s, vld_s, uf_s, err_s;
  logic [7:0]  r_s, g_s, b_s, gray_s;
  logic [15:0] x_s, y_s, ufcnt_s;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  always #5 clk = ~clk;

  lcd_pixel_unpacker dut (
    .iClk(clk), .iRst(rst), .iFrameStart(fs), .iLcd_Req(req), .iShowGray(show),
    .iRd1_data(d1), .iRd2_data(d2), .iRd1_empty(e1), .iRd2_empty(e2),
    .oRd_req(rdreq), .oR(r), .oG(g), .oB(b), .oGray(gray), .oPix_valid(vld),
    .oX(x), .oY(y), .oUnderflow(uf), .oUnderflow_cnt(ufcnt), .oFrame_err(err)
  );

  lcd_pixel_unpacker #(.H_ACTIVE(4), .V_ACTIVE(2), .FILL_RGB(24'h000000)) dut_s (
    .iClk(clk), .iRst(rst), .iFrameStart(fs), .iLcd_Req(req), .iShowGray(show),
    .iRd1_data(d1), .iRd2_data(d2), .iRd1_empty(e1), .iRd2_empty(e2),
    .oRd_req(rdreq_s), .oR(r_s), .oG(g_s), .oB(b_s), .oGray(gray_s), .oPix_valid(vld_s),
    .oX(x_s), .oY(y_s), .oUnderflow(uf_s), .oUnderflow_cnt(ufcnt_s), .oFrame_err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Power-on reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("por_valid", 32'(vld), 32'd0);
    chk("por_x", 32'(x), 32'd0);

    // Reset mid-frame at X = 37
    d1 = 16'hABCD; d2 = 16'h5A5A;
    fs = 1'b1; tick(); fs = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 37; i++) tick();
    chk("pre_rst_valid", 32'(vld), 32'd1);
    chk("pre_rst_x", 32'(x), 32'd35);
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 32'(vld), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_r", 32'(r), 32'd0);
    chk("rst_gray", 32'(gray), 32'd0);
    chk("rst_rdreq", 32'(rdreq), 32'd0);
    tick();
    rst = 1'b0;
    #1 chk("wait_rdreq", 32'(rdreq), 32'd0);
    tick(); tick();
    chk("wait_valid", 32'(vld), 32'd0);

    // Frame start, one request. Mapping of ABCD/5A5A:
    // R=Rd2[9:2]=96, G={Rd1[14:10],Rd2[14:12]}=55, B=Rd1[9:2]=F3, Gray=AA
    req = 1'b0;
    fs = 1'b1; tick(); fs = 1'b0;
    req = 1'b1;
    #1 chk("rdreq_on", 32'(rdreq), 32'd1);
    tick();
    req = 1'b0;
    tick();
    chk("px0_r", 32'(r), 32'h96);
    chk("px0_g", 32'(g), 32'h55);
    chk("px0_b", 32'(b), 32'hF3);
    chk("px0_gray", 32'(gray), 32'hAA);
    chk("px0_valid", 32'(vld), 32'd1);
    chk("px0_x", 32'(x), 32'd0);
    chk("px0_y", 32'(y), 32'd0);
    chk("px0_uf", 32'(uf), 32'd0);
    tick();
    chk("px0_valid_drop", 32'(vld), 32'd0);

    // Show-gray pixel
    req = 1'b1; tick();
    req = 1'b0; show = 1'b1; tick();
    show = 1'b0;
    chk("gray_r", 32'(r), 32'hAA);
    chk("gray_g", 32'(g), 32'hAA);
    chk("gray_b", 32'(b), 32'hAA);
    chk("gray_x", 32'(x), 32'd1);

    // Rd2 empty for 3 requests (X = 2,3,4), then a good request at X = 5
    e2 = 1'b1; req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("uf_rdreq", 32'(rdreq), 32'd0);
      if (i == 2) begin
        chk("uf0_valid", 32'(vld), 32'd1);
        chk("uf0_x", 32'(x), 32'd2);
        chk("uf0_r", 32'(r), 32'd0);
        chk("uf0_gray", 32'(gray), 32'd0);
      end
      tick();
    end
    e2 = 1'b0;
    #1 chk("good_rdreq", 32'(rdreq), 32'd1);
    chk("uf1_x", 32'(x), 32'd3);
    chk("uf1_g", 32'(g), 32'd0);
    tick();
    req = 1'b0;
    chk("uf2_x", 32'(x), 32'd4);
    chk("uf2_b", 32'(b), 32'd0);
    chk("uf_flag", 32'(uf), 32'd1);
    chk("uf_cnt", 32'(ufcnt), 32'd3);
    tick();
    chk("good_valid", 32'(vld), 32'd1);
    chk("good_x", 32'(x), 32'd5);
    chk("good_r", 32'(r), 32'h96);

    // 4x2 frame: 8 continuous requests, 9th ignored
    rst = 1'b1; #1 rst = 1'b0;
    tick();
    fs = 1'b1; tick(); fs = 1'b0;
    for (int c = 0; c < 12; c++) begin
      req = (c <= 8);
      #1;
      if (c == 8) chk("s_req9_rdreq", 32'(rdreq_s), 32'd0);
      if (c >= 2 && c <= 9) begin
        chk("s_valid", 32'(vld_s), 32'd1);
        chk("s_x", 32'(x_s), 32'((c - 2) % 4));
        chk("s_y", 32'(y_s), 32'((c - 2) / 4));
      end
      if (c >= 10) chk("s_req9_valid", 32'(vld_s), 32'd0);
      tick();
    end

    // Early frame start after 5 of 8 pixels (3rd one underflows)
    rst = 1'b1; #1 rst = 1'b0;
    tick();
    fs = 1'b1; tick(); fs = 1'b0;
    for (int c = 0; c < 5; c++) begin
      req = 1'b1;
      e1 = (c == 2);
      tick();
    end
    req = 1'b0; e1 = 1'b0; fs = 1'b1;
    chk("e_cnt_before", 32'(ufcnt_s), 32'd1);
    chk("e_err_before", 32'(err_s), 32'd0);
    tick();
    fs = 1'b0; req = 1'b1;
    chk("e_err_pulse", 32'(err_s), 32'd1);
    chk("e_cnt_cleared", 32'(ufcnt_s), 32'd0);
    chk("e_uf_cleared", 32'(uf_s), 32'd0);
    chk("e_inflight_valid", 32'(vld_s), 32'd1);
    chk("e_inflight_y", 32'(y_s), 32'd1);
    tick();
    req = 1'b0;
    chk("e_err_drop", 32'(err_s), 32'd0);
    tick();
    chk("e_next_valid", 32'(vld_s), 32'd1);
    chk("e_next_x", 32'(x_s), 32'd0);
    chk("e_next_y", 32'(y_s), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
